// File: rtl/rng_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rng_sample_fifo
//  Purpose  : Output buffer for the rng block. Every cycle in which in_valid
//             is high offers one BY-bit sample. Each accepted sample is written
//             into a DEPTH-entry circular FIFO. The FIFO is first-word
//             fall-through and hands samples to the consumer over ready/valid.
//             When the FIFO is full and nothing is popped, the offered sample
//             is dropped and the sticky overflow flag is set.
//  Ports    :
//    clk        in   1      rising-edge clock
//    rst        in   1      synchronous active-high reset
//    in_sample  in   BY     sample from rng
//    in_valid   in   1      one sample offered per high cycle
//    out_data   out  BY     head-of-FIFO sample, 0 while empty
//    out_valid  out  1      FIFO non-empty
//    out_ready  in   1      consumer takes out_data this cycle
//    level      out  AW+1   occupancy 0..DEPTH
//    full       out  1      level == DEPTH
//    empty      out  1      level == 0
//    overflow   out  1      sticky: a sample was dropped
//    ovf_clear  in   1      clears overflow (and drop_count)
//    drop_count out  16     (RNG_FIFO_STATS_EN only) saturating drop counter
//  Config   : define RNG_FIFO_STATS_EN to add the drop_count output.
//  Revision : 1.0  initial release
// ============================================================================
module rng_sample_fifo #(
  parameter  int BY    = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BY-1:0] in_sample,
  input  logic          in_valid,
  output logic [BY-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  input  logic          ovf_clear
`ifdef RNG_FIFO_STATS_EN
  ,
  output logic [15:0]   drop_count
`endif
);

  localparam logic [AW:0] c_FULL_LEVEL = DEPTH[AW:0];

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [BY-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q,  level_d;
  logic          overflow_q, overflow_d;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Status comes only from the registered level. This keeps in_valid away
  // from every out_* output.
  assign w_full  = (level_q == c_FULL_LEVEL);
  assign w_empty = (level_q == '0);

  // A full FIFO still accepts a sample when the head is popped in the same
  // cycle. That is the one allowed combinational path, out_ready -> push.
  assign w_pop  = !w_empty && out_ready;
  assign w_push = in_valid && (!w_full || w_pop);
  assign w_drop = in_valid && w_full && !w_pop;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    // Pointers are exactly AW bits wide, so DEPTH-1 wraps to 0 on its own.
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (w_push && !w_pop) begin
      level_d = level_q + 1'b1;
    end else if (w_pop && !w_push) begin
      level_d = level_q - 1'b1;
    end

    // A drop has priority over a clear in the same cycle.
    if (w_drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clear) begin
      overflow_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset. out_data is masked while empty, so stale contents
  // never reach the consumer. Writes are gated during reset so that an
  // in_valid in the reset cycle has no effect.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      mem_q[wr_ptr_q] <= in_sample;
    end
  end

  // --------------------------------------------------------------------------
  // Optional drop statistics
  // --------------------------------------------------------------------------
`ifdef RNG_FIFO_STATS_EN
  logic [15:0] drop_count_q, drop_count_d;

  always_comb begin
    drop_count_d = drop_count_q;
    if (ovf_clear) begin
      // A drop in the clearing cycle is counted against the fresh count.
      drop_count_d = w_drop ? 16'd1 : 16'd0;
    end else if (w_drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_data  = w_empty ? '0 : mem_q[rd_ptr_q];
  assign out_valid = !w_empty;
  assign level     = level_q;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_rng_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rng_sample_fifo
//  Purpose  : Directed bench for rng_sample_fifo. The driver keeps a small
//             occupancy/flag model and queues each accepted sample. A
//             negedge monitor pops the queue and compares it with every
//             sample the DUT hands over.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rng_sample_fifo;

  localparam int BY    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic [BY-1:0] in_sample;
  logic          in_valid;
  logic [BY-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          ovf_clear;
`ifdef RNG_FIFO_STATS_EN
  logic [15:0]   drop_count;
`endif

  rng_sample_fifo #(.BY(BY), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_sample (in_sample),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
`ifdef RNG_FIFO_STATS_EN
    ,
    .drop_count(drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [BY-1:0] exp_q[$];
  int            exp_level = 0;
  logic          exp_ovf   = 1'b0;
  int            exp_dc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid and ready
  // are both high. Compare the presented head against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none (t=%0t)", out_data, $time);
      end else begin
        chk("out_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // One clock cycle. Inputs are applied 1 time unit after the previous edge.
  // The model is advanced and the status is checked 1 unit after this edge.
  task automatic cyc(input logic iv, input logic [BY-1:0] s, input logic ordy,
                     input logic clr, input logic r);
    logic pop_m, push_m, drop_m;
    in_valid  = iv;
    in_sample = s;
    out_ready = ordy;
    ovf_clear = clr;
    rst       = r;
    pop_m  = (exp_level > 0) && ordy;
    push_m = iv && ((exp_level < DEPTH) || pop_m);
    drop_m = iv && (exp_level == DEPTH) && !pop_m;
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      exp_level = 0;
      exp_ovf   = 1'b0;
      exp_dc    = 0;
    end else begin
      if (push_m) exp_q.push_back(s);
      if (push_m && !pop_m) exp_level++;
      else if (pop_m && !push_m) exp_level--;
      if (drop_m) exp_ovf = 1'b1;
      else if (clr) exp_ovf = 1'b0;
      if (clr) exp_dc = drop_m ? 1 : 0;
      else if (drop_m && exp_dc != 16'hFFFF) exp_dc++;
    end
    chk("level",     {27'h0, level},     exp_level);
    chk("full",      {31'h0, full},      {31'h0, exp_level == DEPTH});
    chk("empty",     {31'h0, empty},     {31'h0, exp_level == 0});
    chk("out_valid", {31'h0, out_valid}, {31'h0, exp_level != 0});
    chk("overflow",  {31'h0, overflow},  {31'h0, exp_ovf});
    if (exp_level == 0) chk("out_data_empty", {16'h0, out_data}, 32'h0);
`ifdef RNG_FIFO_STATS_EN
    chk("drop_count", {16'h0, drop_count}, exp_dc);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sample = '0; out_ready = 1'b0; ovf_clear = 1'b0;

    // Reset for two cycles with in_valid high; the offered sample is ignored.
    cyc(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b1);

    // Fill to full, then offer one more sample, which must be dropped.
    for (int i = 1; i <= 16; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
    chk("head_after_fill", {16'h0, out_data}, 32'h0001);
    cyc(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);

    // Pop 8, push 8 across the pointer wrap, then drain all 16.
    repeat (8) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0);
    repeat (16) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("drained_scoreboard", exp_q.size(), 32'd0);

    // Clear overflow on its own.
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Refill, then run 20 cycles of simultaneous push and pop while full.
    for (int i = 0; i < 16; i++) cyc(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 16'h0300 + 16'(i), 1'b1, 1'b0, 1'b0);

    // Drop and clear in the same cycle: the drop wins. Then clear alone.
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Three drops in a row.
    repeat (3) cyc(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    repeat (16) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream with five samples stored.
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0400 + 16'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h5555, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0);
    chk("post_reset_head", {16'h0, out_data}, 32'h0000ABCD);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("final_scoreboard", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
